// File: rtl/hack_memory_map_pkg.sv
// rtl/hack_memory_map_pkg.sv - shared region-decode constants, clog2 helper and scan-FSM encoding
package hack_memory_map_pkg;

  localparam int DEF_RAM_DEPTH = 16384;
  localparam int DEF_SCR_DEPTH = 8192;
  localparam int DEF_SCR_BASE  = DEF_RAM_DEPTH;
  localparam int DEF_KBD_ADDR  = DEF_RAM_DEPTH + DEF_SCR_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // The screen follows RAM directly; the keyboard word follows the screen.
  function automatic int scr_base_of(input int ram_depth);
    return ram_depth;
  endfunction

  function automatic int kbd_addr_of(input int ram_depth, input int scr_depth);
    return ram_depth + scr_depth;
  endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// rtl/hack_kbd_fifo.sv - keyboard code FIFO; zero codes are handshaken but dropped
module hack_kbd_fifo
  import hack_memory_map_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W-1:0]           push_data,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic                   pop,
  output logic [clog2(DEPTH):0]  count,
  output logic [W-1:0]           head
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_store;
  logic          do_pop;

  // Ready looks only at occupancy so it never depends on a same-cycle pop.
  assign push_ready = (count != CW'(DEPTH));
  assign do_store   = push_valid && push_ready && (push_data != '0);
  assign do_pop     = pop && (count != '0);
  assign head       = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_store) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({do_store, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hack_memory_map.sv
// rtl/hack_memory_map.sv - Hack data-memory map: RAM, screen with scan-out port, keyboard FIFO
module hack_memory_map
  import hack_memory_map_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int SCR_DEPTH = DEF_SCR_DEPTH,
  parameter int KBD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            in,
  input  logic                         load,
  input  logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            out,
  output logic                         addr_err,
  input  logic [DATA_W-1:0]            kbd_code,
  input  logic                         kbd_valid,
  output logic                         kbd_ready,
  output logic [clog2(KBD_DEPTH):0]    kbd_count,
  input  logic                         scan_start,
  output logic                         scan_busy,
  output logic                         scan_valid,
  output logic [DATA_W-1:0]            scan_data,
  output logic [clog2(SCR_DEPTH)-1:0]  scan_idx,
  output logic                         scan_last
);

  localparam int RAM_AW = clog2(RAM_DEPTH);
  localparam int SCR_AW = clog2(SCR_DEPTH);
  localparam logic [ADDR_W-1:0] SCR_BASE = ADDR_W'(scr_base_of(RAM_DEPTH));
  localparam logic [ADDR_W-1:0] KBD_ADDR = ADDR_W'(kbd_addr_of(RAM_DEPTH, SCR_DEPTH));
  localparam logic [SCR_AW-1:0] SCAN_END = SCR_AW'(SCR_DEPTH - 1);

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] scr [SCR_DEPTH];

  logic              in_ram;
  logic              in_scr;
  logic              in_kbd;
  logic [RAM_AW-1:0] ram_a;
  logic [SCR_AW-1:0] scr_a;
  logic [DATA_W-1:0] kbd_head;

  assign in_ram   = (address < SCR_BASE);
  assign in_scr   = !in_ram && (address < KBD_ADDR);
  assign in_kbd   = (address == KBD_ADDR);
  assign addr_err = (address > KBD_ADDR);
  assign ram_a    = RAM_AW'(address);
  assign scr_a    = SCR_AW'(address - SCR_BASE);

  always_comb begin
    out = '0;
    if (in_ram)      out = ram[ram_a];
    else if (in_scr) out = scr[scr_a];
    else if (in_kbd) out = kbd_head;
  end

  always_ff @(posedge clk) begin
    if (load && in_ram) ram[ram_a] <= in;
    if (load && in_scr) scr[scr_a] <= in;
  end

  hack_kbd_fifo #(
    .W     (DATA_W),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_data  (kbd_code),
    .push_valid (kbd_valid),
    .push_ready (kbd_ready),
    .pop        (load && in_kbd),
    .count      (kbd_count),
    .head       (kbd_head)
  );

  scan_state_t       state;
  logic [SCR_AW-1:0] scan_ptr;

  // Scan reads are registered at the same edge as CPU writes, so a colliding word returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scan_ptr   <= '0;
      scan_busy  <= 1'b0;
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
      scan_data  <= '0;
      scan_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          scan_valid <= 1'b0;
          scan_last  <= 1'b0;
          if (scan_start) begin
            state     <= ST_SCAN;
            scan_ptr  <= '0;
            scan_busy <= 1'b1;
          end
        end
        ST_SCAN: begin
          scan_data  <= scr[scan_ptr];
          scan_idx   <= scan_ptr;
          scan_valid <= 1'b1;
          scan_ptr   <= scan_ptr + SCR_AW'(1);
          if (scan_ptr == SCAN_END) begin
            scan_last <= 1'b1;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state      <= ST_IDLE;
          scan_busy  <= 1'b0;
          scan_valid <= 1'b0;
          scan_last  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_memory_map.sv
// tb/tb_hack_memory_map.sv - scoreboard bench for hack_memory_map
module tb_hack_memory_map;

  localparam int SCR_DEPTH = 8192;
  localparam int KBD       = 'h6000;

  localparam int K_OUT = 0, K_ERR = 1, K_CNT = 2, K_RDY = 3, K_BUSY = 4;
  localparam int K_SVAL = 5, K_SLAST = 6, K_SDATA = 7, K_SIDX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [14:0] address = '0;
  logic [15:0] out;
  logic        addr_err;
  logic [15:0] kbd_code = '0;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready;
  logic [2:0]  kbd_count;
  logic        scan_start = 1'b0;
  logic        scan_busy;
  logic        scan_valid;
  logic [15:0] scan_data;
  logic [12:0] scan_idx;
  logic        scan_last;

  int    kind_q[$];
  int    exp_q[$];
  string name_q[$];
  int    scan_q[$];
  int    checks = 0;
  int    failures = 0;

  hack_memory_map dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address),
    .out(out), .addr_err(addr_err), .kbd_code(kbd_code), .kbd_valid(kbd_valid),
    .kbd_ready(kbd_ready), .kbd_count(kbd_count), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_valid(scan_valid), .scan_data(scan_data),
    .scan_idx(scan_idx), .scan_last(scan_last)
  );

  always #5 clk = ~clk;

  function automatic int dut_val(input int k);
    case (k)
      K_OUT:   return int'(out);
      K_ERR:   return int'(addr_err);
      K_CNT:   return int'(kbd_count);
      K_RDY:   return int'(kbd_ready);
      K_BUSY:  return int'(scan_busy);
      K_SVAL:  return int'(scan_valid);
      K_SLAST: return int'(scan_last);
      K_SDATA: return int'(scan_data);
      default: return int'(scan_idx);
    endcase
  endfunction

  task automatic expect_val(input int k, input int e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic check_int(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  // Monitor: drains queued expectations and every scan beat at the falling edge.
  always @(negedge clk) begin : monitor
    int    k, e, a, ei;
    string n;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = dut_val(k);
      checks++;
      if (a != e) begin
        failures++;
        $display("FAIL %s actual=0x%0h expected=0x%0h", n, a, e);
      end
    end
    if (scan_valid) begin
      if (scan_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scan_extra_beat idx=%0d expected=no_beat", scan_idx);
      end else begin
        ei = scan_q.pop_front();
        check_int("scan_idx", int'(scan_idx), ei);
        check_int("scan_data", int'(scan_data), ei);
        check_int("scan_last", int'(scan_last), (ei == SCR_DEPTH - 1) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input int e, input string n);
    expect_val(k, e, n);
    tick();
  endtask

  task automatic wr(input int a, input int d);
    address = 15'(a);
    in = 16'(d);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic rd(input int a, input int e, input string n);
    address = 15'(a);
    load = 1'b0;
    chk(K_OUT, e, n);
  endtask

  task automatic kpush(input int c);
    kbd_code = 16'(c);
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    tick();
    expect_val(K_CNT, 0, "rst_count");
    expect_val(K_RDY, 1, "rst_ready");
    expect_val(K_BUSY, 0, "rst_busy");
    expect_val(K_SVAL, 0, "rst_valid");
    expect_val(K_SLAST, 0, "rst_last");
    expect_val(K_SDATA, 0, "rst_data");
    expect_val(K_SIDX, 0, "rst_idx");
    tick();
    rst_n = 1'b1;
    tick();

    // RAM / screen basics
    wr(0, 'hFFFF);
    rd(0, 'hFFFF, "ram0_neg1");
    wr('h4000, 0);
    rd('h4000, 0, "scr0_zero");
    rd(0, 'hFFFF, "ram0_kept");
    wr(5, 11);
    address = 15'd5; in = 16'd77; load = 1'b1;
    expect_val(K_OUT, 11, "same_cycle_old");
    tick();
    load = 1'b0;
    chk(K_OUT, 77, "same_cycle_new");
    wr('h0234, 0);
    wr('h2000, 2222);
    wr('h4234, 1234);
    rd('h2000, 2222, "ram_2000");
    rd('h4234, 1234, "scr_4234");
    rd('h0234, 0, "ram_0234_indep");

    // Keyboard FIFO ordering and pop
    kpush('h41); kpush('h42); kpush('h43);
    chk(K_CNT, 3, "kbd_cnt3");
    rd(KBD, 'h41, "kbd_head41");
    wr(KBD, 'h1234);
    rd(KBD, 'h42, "kbd_head42");
    chk(K_CNT, 2, "kbd_cnt2");
    wr(KBD, 0); wr(KBD, 0);
    chk(K_CNT, 0, "kbd_cnt0");
    rd(KBD, 0, "kbd_empty_read");
    wr(KBD, 0);
    chk(K_CNT, 0, "kbd_pop_empty");
    kpush(0);
    chk(K_CNT, 0, "kbd_zero_code");

    // Full FIFO, held-off push, ready independent of pop
    for (int i = 1; i <= 4; i++) kpush(i);
    expect_val(K_CNT, 4, "kbd_cnt4");
    chk(K_RDY, 0, "kbd_full_ready");
    kbd_code = 16'd5; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    chk(K_CNT, 4, "kbd_fifth_held");
    kbd_code = 16'd5; kbd_valid = 1'b1; address = 15'(KBD); load = 1'b1;
    expect_val(K_RDY, 0, "kbd_ready_no_pop_path");
    tick();
    kbd_valid = 1'b0; load = 1'b0;
    chk(K_CNT, 3, "kbd_pop_at_full");
    rd(KBD, 2, "kbd_head2");
    kbd_code = 16'd6; kbd_valid = 1'b1; address = 15'(KBD); load = 1'b1;
    tick();
    kbd_valid = 1'b0; load = 1'b0;
    chk(K_CNT, 3, "kbd_push_pop_cnt");
    rd(KBD, 3, "kbd_head3");
    wr(KBD, 0);
    rd(KBD, 4, "kbd_head4");
    wr(KBD, 0);
    rd(KBD, 6, "kbd_head6_wrap");
    wr(KBD, 0);
    chk(K_CNT, 0, "kbd_drained");

    // Address errors and discarded writes
    address = 15'h6001;
    expect_val(K_ERR, 1, "err_6001");
    chk(K_OUT, 0, "out_6001");
    address = 15'h7FFF;
    chk(K_ERR, 1, "err_7fff");
    address = 15'(KBD);
    chk(K_ERR, 0, "err_kbd");
    address = 15'h5FFF;
    chk(K_ERR, 0, "err_scr_last");
    wr('h3FFF, 1); wr('h5FFF, 2); wr('h2001, 3); wr('h4001, 4);
    kpush('h77);
    wr('h7FFF, 9999);
    wr('h6001, 5555);
    chk(K_CNT, 1, "bad_write_no_pop");
    rd('h3FFF, 1, "bad_wr_ram3fff");
    rd('h5FFF, 2, "bad_wr_scr5fff");
    rd('h2001, 3, "bad_wr_ram2001");
    rd('h4001, 4, "bad_wr_scr4001");
    rd(0, 'hFFFF, "bad_wr_ram0");
    rd('h4234, 1234, "bad_wr_scr4234");
    wr(KBD, 0);

    // Full scan with a colliding CPU write and a start pulse while busy
    for (int i = 0; i < SCR_DEPTH; i++) wr('h4000 + i, i);
    for (int i = 0; i < SCR_DEPTH; i++) scan_q.push_back(i);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    expect_val(K_BUSY, 1, "scan_busy_on");
    n = 0;
    while (scan_busy && n < 20000) begin
      scan_start = (n == 50);
      if (n == 100) begin
        address = 15'('h4000 + 100); in = 16'hBEEF; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      n++;
    end
    scan_start = 1'b0; load = 1'b0;
    check_int("scan_cycles", n, SCR_DEPTH + 1);
    check_int("scan_beats_left", scan_q.size(), 0);
    expect_val(K_SVAL, 0, "scan_done_valid");
    chk(K_SLAST, 0, "scan_done_last");
    rd('h4000 + 100, 'hBEEF, "scan_collide_write");
    wr('h4000 + 100, 100);

    // Reset mid-scan
    for (int i = 0; i < 10; i++) scan_q.push_back(i);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    expect_val(K_BUSY, 0, "abort_busy");
    expect_val(K_SVAL, 0, "abort_valid");
    expect_val(K_SLAST, 0, "abort_last");
    expect_val(K_SDATA, 0, "abort_data");
    expect_val(K_SIDX, 0, "abort_idx");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check_int("abort_beats_left", scan_q.size(), 0);
    tick();
    chk(K_BUSY, 0, "abort_idle_stays");
    rd(0, 'hFFFF, "ram_kept_reset");
    rd('h4005, 5, "scr_kept_reset");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_memory_map.md
Name: hack_memory_map

Overview:
- Parametrised successor to the Hack data-memory map: RAM, screen buffer and keyboard in one address space.
- Adds a keyboard FIFO with valid/ready push and write-to-acknowledge pop, address-error detection, and a self-timed screen scan-out port for a display controller.
- Sits between the CPU data port (in/load/address/out) and the I/O devices.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 15, CPU address width.
- RAM_DEPTH, 16384, RAM words, power of 2; RAM occupies 0 .. RAM_DEPTH-1.
- SCR_DEPTH, 8192, screen words, power of 2; screen occupies SCR_BASE=RAM_DEPTH .. SCR_BASE+SCR_DEPTH-1.
- KBD_DEPTH, 4, keyboard FIFO entries, power of 2, >=2; KBD_ADDR = SCR_BASE+SCR_DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in  in  DATA_W  CPU write data
- load  in  1  CPU write enable
- address  in  ADDR_W  CPU address
- out  out  DATA_W  CPU read data, combinational
- addr_err  out  1  address above KBD_ADDR, combinational
- kbd_code  in  DATA_W  key code from keyboard device
- kbd_valid  in  1  key code offered
- kbd_ready  out  1  FIFO can accept
- kbd_count  out  clog2(KBD_DEPTH)+1  FIFO occupancy
- scan_start  in  1  start full-screen scan
- scan_busy  out  1  scan in progress
- scan_valid  out  1  scan_data valid this cycle
- scan_data  out  DATA_W  screen word
- scan_idx  out  clog2(SCR_DEPTH)  word index of scan_data
- scan_last  out  1  final word of scan

Behaviour:
- Reset (async, rst_n=0): FIFO empty (kbd_count=0, kbd_ready=1), scan FSM IDLE, scan_busy/scan_valid/scan_last=0, scan_data=0, scan_idx=0. RAM/screen contents are not cleared.
- Read decode (combinational, zero latency): RAM range -> ram[addr]; screen range -> scr[addr-SCR_BASE]; KBD_ADDR -> FIFO head, or 0 when empty; above KBD_ADDR -> out=0, addr_err=1.
- Writes on the rising edge when load=1: RAM/screen ranges store `in`. Write to KBD_ADDR pops one FIFO entry; `in` is ignored; no effect when empty. Writes to invalid addresses are discarded.
- Same-cycle write then read of the same address: out shows the old value until the edge, the new value after it.
- Keyboard push: accepted when kbd_valid && kbd_ready. kbd_ready = (kbd_count != KBD_DEPTH); it is not combinationally dependent on a same-cycle pop.
- kbd_code==0 with a handshake: accepted but not stored.
- Push and pop in the same cycle, non-empty: count unchanged, head advances. When empty: push taken, pop ignored.
- Read/write pointers wrap modulo KBD_DEPTH.
- Scan FSM states:
  - IDLE: scan_start=1 -> SCAN, internal index=0, scan_busy=1.
  - SCAN: each cycle issue read of scr[index] and increment. Data is registered, 1-cycle latency: scan_valid=1 and scan_idx=index-1 the cycle after each read. After issuing index SCR_DEPTH-1 -> DRAIN.
  - DRAIN: emit the last word with scan_last=1 -> IDLE; scan_busy drops the same cycle it returns to IDLE.
- scan_start while busy is ignored. A full scan is SCR_DEPTH+1 cycles from scan_start to scan_busy=0.
- Scan port is read-before-write: a CPU write to the word being scanned in the same cycle returns old data.
- rst_n asserted mid-scan aborts immediately to IDLE with all scan outputs 0.

Decomposition:
- Shared package: region-decode constants (SCR_BASE, KBD_ADDR), clog2 helper, scan-FSM state encoding (IDLE/SCAN/DRAIN).
- One sub-module, hack_kbd_fifo: parametrised synchronous FIFO, async active-low reset, push/pop/count/head.
- RAM and screen arrays stay inline; the screen array is dual-port (CPU read/write, scan read).

Test Plan:
- Write -1 at address 0, then read 0 with load=0 -> out=-1; read 0x4000 -> out unaffected (0 after a prior write of 0).
- Write 2222 at 0x2000 and 1234 at 0x4234; read both -> 2222 and 1234; read 0x0234 -> not 1234, proving regions are independent.
- Push 0x41, 0x42, 0x43 -> kbd_count=3; read 0x6000 -> 0x41; write 0x6000 -> next read 0x42, count=2.
- Push 5 codes into depth 4 -> kbd_ready=0 after the 4th, 5th held off; simultaneous pop+push when count=3 -> count stays 3.
- Read 0x6001 -> out=0, addr_err=1; write 9999 to 0x7FFF, then read RAM/screen checksums -> unchanged.
- Fill scr[i]=i, pulse scan_start -> SCR_DEPTH valid beats, scan_data=scan_idx, scan_last on idx SCR_DEPTH-1; second run with rst_n low at beat 10 -> outputs 0, FSM IDLE.
